down_timer: RTL and testbench
=============================

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; the block SHALL support 2..16.
REQ-002 clk  input  1  single clock; all state updates on its falling edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  parallel-load strobe, sampled per clk edge.
REQ-005 load_val  input  WIDTH  value captured on load.
REQ-006 start  input  1  begin countdown request.
REQ-007 enable  input  1  count-enable qualifier while running.
REQ-008 auto_reload  input  1  1 = reload and keep running at terminal count; 0 = one-shot.
REQ-009 q  output  WIDTH  current count, registered.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.
REQ-012 tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE; busy and done SHALL be decoded from state only.
REQ-014 load SHALL have top priority in every state: q <= load_val, reload_reg <= load_val, state -> IDLE, tc <= 0.
REQ-015 In IDLE or DONE, start with q != 0 and load low SHALL move the FSM to RUN; q is unchanged on that edge.
REQ-016 In IDLE or DONE, start with q == 0 SHALL assert tc for one cycle and move the FSM to DONE.
REQ-017 In RUN with enable high and q > 1, the block SHALL decrement q by 1 on that edge.
REQ-018 In RUN with enable low, q and state SHALL hold and tc SHALL be 0.
REQ-019 In RUN with enable high and q == 1, the block SHALL assert tc for that one cycle and then:
  - auto_reload = 1 and reload_reg != 0: q <= reload_reg, stay in RUN;
  - otherwise: q <= 0, go to DONE.
REQ-020 auto_reload SHALL be sampled only on the terminal edge; changing it mid-count SHALL have no other effect.
REQ-021 start asserted while in RUN SHALL be ignored.
REQ-022 With auto_reload = 1 and reload_reg == 1, tc SHALL be high on every enabled cycle.
REQ-023 Decrement SHALL be modulo-free: q never wraps below 0. The 0 -> all-ones transition SHALL be unreachable.
REQ-024 tc SHALL be 0 on every cycle not named in REQ-016 and REQ-019.
REQ-025 Latency from the start edge to the first decrement SHALL be one enabled clk edge.

Reset
REQ-026 reset high SHALL immediately force q = 0, reload_reg = 0, state = IDLE, busy = 0, done = 0, tc = 0, independent of clk.
REQ-027 reset asserted mid-count SHALL abort the countdown with no tc pulse.
REQ-028 After reset deasserts, the block SHALL remain in IDLE until load or start.

Structure
REQ-029 The state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) SHALL live in a shared include file, counter_defs.vh, reused by later counter blocks.
REQ-030 One sub-module, down_cnt_core, SHALL hold q and reload_reg and provide the decrement and q == 0 / q == 1 detection; the FSM and tc logic SHALL stay in down_timer.
REQ-031 The block SHALL contain no latches and no derived clocks; q SHALL NOT be ripple-clocked.

Verification
REQ-032 reset pulse 15 ns, load_val = 5, load, start, enable = 1, auto_reload = 0 -> q = 5,4,3,2,1,0; one tc with q 1 -> 0; done = 1; busy = 0.
REQ-033 load_val = 3, auto_reload = 1, start, enable = 1 for 10 edges -> q = 3,2,1,3,2,1,3,2,1,3; tc on edges 3, 6, 9; busy stays 1.
REQ-034 load_val = 6, start, enable toggled 1,0,1,0 -> q steps only on enabled edges (6,5,5,4,4); tc = 0 throughout.
REQ-035 load_val = 0, start -> tc pulse on the start edge, FSM in DONE, q = 0.
REQ-036 load_val = 9, start, count to q = 4, assert reset between edges -> q = 0, IDLE, no tc; then load 2, start -> normal countdown 2,1,0.
REQ-037 In RUN at q = 5, assert load with load_val = 7 and start together -> q = 7, IDLE; a second start is needed to resume.

Source files
------------

// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared types for the down_timer block.
//   state_e     - FSM states, encodings taken from counter_defs.vh
//   cnt_op_e    - per-edge command from the FSM to the count core
//   cnt_flags_t - combinational status bus from the count core
`include "counter_defs.vh"

package down_timer_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned OP_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = `CNT_ST_IDLE,
        ST_RUN  = `CNT_ST_RUN,
        ST_DONE = `CNT_ST_DONE
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_LOAD   = 3'd1,
        OP_DEC    = 3'd2,
        OP_RELOAD = 3'd3,
        OP_CLEAR  = 3'd4
    } cnt_op_e;

    typedef struct packed {
        logic zero;         // q == 0
        logic one;          // q == 1
        logic reload_zero;  // reload_reg == 0
    } cnt_flags_t;

endpackage

// File: rtl/counter_defs.vh
// Shared counter FSM state encodings, reused by the counter family.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH

`define CNT_ST_IDLE 2'd0
`define CNT_ST_RUN  2'd1
`define CNT_ST_DONE 2'd2

`endif

// File: rtl/down_cnt_core.sv
// down_cnt_core: datapath of the down timer. Holds the count (q) and the
// reload register, applies one command per falling clk edge and reports
// zero/one detection for the controlling FSM.
// Ports:
//   clk         - clock, state updates on falling edge
//   reset       - asynchronous active-high reset
//   i_op        - command for this edge (hold/load/dec/reload/clear)
//   i_load_val  - value captured into q and reload_reg on OP_LOAD
//   o_q         - registered count
//   o_flags_c   - combinational zero/one/reload-zero flags
module down_cnt_core
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  cnt_op_e          i_op,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output cnt_flags_t       o_flags_c
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_q_dec;

    assign w_q_dec = r_q - WIDTH'(1);

    // Count and reload registers
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_q      <= '0;
            r_reload <= '0;
        end else begin
            case (i_op)
                OP_LOAD: begin
                    r_q      <= i_load_val;
                    r_reload <= i_load_val;
                end
                OP_DEC: begin
                    // Floor at zero so the count can never wrap to all-ones
                    if (r_q != '0) begin
                        r_q <= w_q_dec;
                    end
                end
                OP_RELOAD: r_q <= r_reload;
                OP_CLEAR:  r_q <= '0;
                default:   r_q <= r_q;
            endcase
        end
    end

    // Terminal-count detection for the FSM
    always_comb begin
        o_flags_c             = '0;
        o_flags_c.zero        = (r_q == '0);
        o_flags_c.one         = (r_q == WIDTH'(1));
        o_flags_c.reload_zero = (r_reload == '0);
    end

    assign o_q = r_q;

endmodule

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with IDLE/RUN/DONE control, one-shot
// or auto-reload operation and a registered terminal-count pulse.
// All state changes on the falling edge of clk.
// Ports:
//   clk          - clock (falling-edge active)
//   reset        - asynchronous active-high reset
//   load         - parallel load strobe, top priority, returns to IDLE
//   load_val     - value captured on load
//   start        - begin countdown from IDLE/DONE
//   enable       - count enable while running
//   auto_reload  - reload at terminal count (sampled on terminal edge only)
//   q            - current count
//   busy         - high in RUN
//   done         - high in DONE
//   tc           - one-cycle terminal-count pulse
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_e           r_state;
    state_e           w_state_nxt;
    cnt_op_e          w_op;
    cnt_flags_t       w_flags;
    logic             w_tc_nxt;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_q;

    down_cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_op       (w_op),
        .i_load_val (load_val),
        .o_q        (w_q),
        .o_flags_c  (w_flags)
    );

    // State register; busy/done are the registered decode of the next state
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state, core command and terminal-count decode
    always_comb begin
        w_state_nxt = r_state;
        w_op        = OP_HOLD;
        w_tc_nxt    = 1'b0;

        if (load) begin
            w_op        = OP_LOAD;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (w_flags.zero) begin
                            // Starting from zero is an immediate terminal count
                            w_tc_nxt    = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (w_flags.one) begin
                            w_tc_nxt = 1'b1;
                            if (auto_reload && !w_flags.reload_zero) begin
                                w_op = OP_RELOAD;
                            end else begin
                                w_op        = OP_CLEAR;
                                w_state_nxt = ST_DONE;
                            end
                        end else if (w_flags.zero) begin
                            // Not reachable by construction; leave RUN cleanly
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_op = OP_DEC;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign q    = w_q;
    assign busy = r_busy;
    assign done = r_done;
    assign tc   = r_tc;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer with a scoreboard of expected outputs.
module tb_down_timer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         enable = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;

    typedef struct {
        int q;
        int tc;
        int busy;
        int done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   t2_q [10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};

    down_timer #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expectation, let the falling edge
    // act, then pop and compare on the following rising edge.
    task automatic step(input string tag, input int ld, input int lv, input int st,
                        input int en, input int ar,
                        input int eq, input int etc, input int eb, input int ed);
        exp_t e;
        load        = 1'(ld);
        load_val    = W'(lv);
        start       = 1'(st);
        enable      = 1'(en);
        auto_reload = 1'(ar);
        sb.push_back('{eq, etc, eb, ed});
        @(negedge clk);
        @(posedge clk);
        e = sb.pop_front();
        chk({tag, ".q"},    32'(q),    32'(e.q));
        chk({tag, ".tc"},   32'(tc),   32'(e.tc));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".done"}, 32'(done), 32'(e.done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset pulse of 15 ns, checked asynchronously between edges
        #1 reset = 1'b1;
        #2;
        chk("rst.q",    32'(q),    32'(0));
        chk("rst.tc",   32'(tc),   32'(0));
        chk("rst.busy", 32'(busy), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        #13 reset = 1'b0;
        @(posedge clk);

        // One-shot countdown from 5
        step("t1_load",  1, 5, 0, 0, 0,  5, 0, 0, 0);
        step("t1_start", 0, 0, 1, 1, 0,  5, 0, 1, 0);
        for (int v = 4; v >= 1; v--) begin
            step("t1_dec", 0, 0, 0, 1, 0,  v, 0, 1, 0);
        end
        step("t1_tc",    0, 0, 0, 1, 0,  0, 1, 0, 1);
        step("t1_hold",  0, 0, 0, 1, 0,  0, 0, 0, 1);

        // Auto-reload from 3, with a stray start mid-run
        step("t2_load",  1, 3, 0, 0, 1,  3, 0, 0, 0);
        step("t2_start", 0, 0, 1, 1, 1,  3, 0, 1, 0);
        for (int e = 1; e <= 10; e++) begin
            step("t2_run", 0, 0, (e == 4) ? 1 : 0, 1, 1,
                 t2_q[e-1], (e % 3 == 0) ? 1 : 0, 1, 0);
        end

        // Auto-reload of 1: terminal count on every enabled edge
        step("t2b_load",  1, 1, 0, 0, 1,  1, 0, 0, 0);
        step("t2b_start", 0, 0, 1, 1, 1,  1, 0, 1, 0);
        for (int e = 0; e < 3; e++) begin
            step("t2b_run", 0, 0, 0, 1, 1,  1, 1, 1, 0);
        end

        // Enable gating, auto_reload toggled mid-count without effect
        step("t3_load",  1, 6, 0, 0, 0,  6, 0, 0, 0);
        step("t3_start", 0, 0, 1, 0, 0,  6, 0, 1, 0);
        step("t3_en1",   0, 0, 0, 1, 0,  5, 0, 1, 0);
        step("t3_en0",   0, 0, 0, 0, 1,  5, 0, 1, 0);
        step("t3_en1b",  0, 0, 0, 1, 1,  4, 0, 1, 0);
        step("t3_en0b",  0, 0, 0, 0, 0,  4, 0, 1, 0);

        // Start from zero: immediate terminal count into DONE
        step("t4_load",  1, 0, 0, 0, 0,  0, 0, 0, 0);
        step("t4_start", 0, 0, 1, 1, 0,  0, 1, 0, 1);
        step("t4_hold",  0, 0, 0, 1, 0,  0, 0, 0, 1);

        // Reset mid-count aborts without a pulse
        step("t5_load",  1, 9, 0, 0, 0,  9, 0, 0, 0);
        step("t5_start", 0, 0, 1, 1, 0,  9, 0, 1, 0);
        for (int v = 8; v >= 4; v--) begin
            step("t5_dec", 0, 0, 0, 1, 0,  v, 0, 1, 0);
        end
        reset = 1'b1;
        #1;
        chk("t5_rst.q",    32'(q),    32'(0));
        chk("t5_rst.tc",   32'(tc),   32'(0));
        chk("t5_rst.busy", 32'(busy), 32'(0));
        chk("t5_rst.done", 32'(done), 32'(0));
        #1 reset = 1'b0;
        step("t5_idle",   0, 0, 0, 1, 0,  0, 0, 0, 0);
        step("t5_load2",  1, 2, 0, 0, 0,  2, 0, 0, 0);
        step("t5_start2", 0, 0, 1, 1, 0,  2, 0, 1, 0);
        step("t5_dec2",   0, 0, 0, 1, 0,  1, 0, 1, 0);
        step("t5_tc2",    0, 0, 0, 1, 0,  0, 1, 0, 1);

        // Load beats start while running; a fresh start is needed
        step("t6_load",    1, 6, 0, 0, 0,  6, 0, 0, 0);
        step("t6_start",   0, 0, 1, 1, 0,  6, 0, 1, 0);
        step("t6_dec",     0, 0, 0, 1, 0,  5, 0, 1, 0);
        step("t6_ldst",    1, 7, 1, 1, 0,  7, 0, 0, 0);
        step("t6_idle",    0, 0, 0, 1, 0,  7, 0, 0, 0);
        step("t6_restart", 0, 0, 1, 1, 0,  7, 0, 1, 0);
        step("t6_dec2",    0, 0, 0, 1, 0,  6, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
